cache_flush_request_generator: RTL and testbench

- Sequential request generator that sweeps every line of the system cache to flush it.
- Issues one read request per line at `base_address + line_index*line_bytes`, then waits for all responses before signalling done.
- Sits directly upstream of the cache command generator. It feeds that stage's read request channel during the flush phase, using the package's flush geometry (ways, sets, line size).

---
 rtl/cache_flush_request_generator.sv | 135 +++++++++++++
 tb/tb_cache_flush_request_generator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_flush_request_generator.sv
// cache_flush_request_generator
//
// Walks every line of the system cache once by issuing one read request per
// line at base + line_index * line_bytes. After the last request is accepted
// it waits for all outstanding responses, then pulses done_out.
//
// Ports:
//   ap_clk            clock, rising edge
//   areset            asynchronous active-high reset
//   start_in          one-cycle flush start, honoured only in IDLE
//   base_address_in   flush region base, captured on the accepted start
//   req_valid_out     request valid (held until accepted)
//   req_ready_in      downstream accepts the request
//   req_address_out   line address of the current request
//   resp_valid_in     one pulse per completed response
//   busy_out          high from the accepted start until done
//   done_out          one-cycle completion pulse
//   issued_count_out  requests accepted in the current/last flush
//
// state | meaning
// IDLE  | waiting for start_in
// ISSUE | presenting line addresses, one per handshake
// DRAIN | all lines issued, waiting for outstanding responses
// DONE  | one-cycle done pulse, then back to IDLE

module cache_flush_request_generator #(
  parameter int NUM_WAYS      = 4,
  parameter int LINE_SIZE_LOG = 6,
  parameter int CACHE_SIZE    = 32768,
  parameter int NUM_SETS      = CACHE_SIZE >> (LINE_SIZE_LOG + $clog2(NUM_WAYS)),
  parameter int FLUSH_COUNT   = NUM_SETS * NUM_WAYS,
  parameter int ADDR_W        = 64,
  parameter int CNT_W         = $clog2(FLUSH_COUNT) + 1
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_address_in,
  output logic              req_valid_out,
  input  logic              req_ready_in,
  output logic [ADDR_W-1:0] req_address_out,
  input  logic              resp_valid_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [CNT_W-1:0]  issued_count_out
);

  localparam logic [CNT_W-1:0]  LAST_LINE  = CNT_W'(FLUSH_COUNT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(1) << LINE_SIZE_LOG;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  line_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic              start_acc;
  logic              hs;
  logic              last_hs;
  logic              drain_empty;

  assign start_acc   = (state == S_IDLE) && start_in;
  assign hs          = (state == S_ISSUE) && req_ready_in;
  assign last_hs     = hs && (line_cnt == LAST_LINE);
  // The final response may land in the same cycle we check for completion.
  assign drain_empty = (out_cnt == '0) || ((out_cnt == CNT_ONE) && resp_valid_in);

  // State register
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_in)    state_nxt = S_ISSUE;
      S_ISSUE: if (last_hs)     state_nxt = S_DRAIN;
      S_DRAIN: if (drain_empty) state_nxt = S_DONE;
      S_DONE:                   state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    req_valid_out = (state == S_ISSUE);
    busy_out      = (state != S_IDLE);
    done_out      = (state == S_DONE);
  end

  // Line address is kept as a running sum so each handshake only needs one
  // adder; wrap past 2^ADDR_W falls out of the modulo arithmetic.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      addr_q   <= '0;
      line_cnt <= '0;
    end else if (start_acc) begin
      addr_q   <= base_address_in;
      line_cnt <= '0;
    end else if (hs) begin
      addr_q   <= addr_q + LINE_BYTES;
      line_cnt <= line_cnt + CNT_ONE;
    end
  end

  // Outstanding responses; a stray response at zero is dropped rather than
  // wrapping the counter.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      out_cnt <= '0;
    end else if (start_acc) begin
      out_cnt <= '0;
    end else if (hs && !resp_valid_in) begin
      out_cnt <= out_cnt + CNT_ONE;
    end else if (!hs && resp_valid_in && (out_cnt != '0)) begin
      out_cnt <= out_cnt - CNT_ONE;
    end
  end

  assign req_address_out  = addr_q;
  assign issued_count_out = line_cnt;

endmodule

// File: tb/tb_cache_flush_request_generator.sv
// Testbench for cache_flush_request_generator: default geometry instance plus
// a single-line instance; expected addresses are queued when a flush starts
// and popped on every observed handshake.

module tb_cache_flush_request_generator;

  localparam int FC = 512;
  localparam logic [63:0] LB = 64'd64;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        start_in;
  logic [63:0] base_address_in;
  logic        req_valid_out;
  logic        req_ready_in;
  logic [63:0] req_address_out;
  logic        resp_valid_in;
  logic        busy_out;
  logic        done_out;
  logic [9:0]  issued_count_out;

  logic        s_start;
  logic [63:0] s_base;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_addr;
  logic        s_resp;
  logic        s_busy;
  logic        s_done;
  logic [0:0]  s_issued;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 ap_clk = ~ap_clk;

  cache_flush_request_generator dut (
    .ap_clk(ap_clk), .areset(areset), .start_in(start_in),
    .base_address_in(base_address_in), .req_valid_out(req_valid_out),
    .req_ready_in(req_ready_in), .req_address_out(req_address_out),
    .resp_valid_in(resp_valid_in), .busy_out(busy_out), .done_out(done_out),
    .issued_count_out(issued_count_out)
  );

  cache_flush_request_generator #(
    .NUM_WAYS(1), .LINE_SIZE_LOG(6), .CACHE_SIZE(64)
  ) dut_small (
    .ap_clk(ap_clk), .areset(areset), .start_in(s_start),
    .base_address_in(s_base), .req_valid_out(s_valid),
    .req_ready_in(s_ready), .req_address_out(s_addr),
    .resp_valid_in(s_resp), .busy_out(s_busy), .done_out(s_done),
    .issued_count_out(s_issued)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // ready_mode: 0 always ready, 1 toggle. resp_mode: 0 one cycle after each
  // handshake, 1 all held until issue completes. reset_at>0 aborts after that
  // many handshakes.
  task automatic run_flush(input logic [63:0] base, input int ready_mode,
                           input int resp_mode, input int reset_at,
                           input bit start_mid, input bit start_at_done);
    int hs_cnt = 0;
    int resp_cnt = 0;
    int drain_wait = 0;
    bit hs_prev = 0;
    bit hs;
    bit ready;
    bit resp;
    bit held = 0;
    bit expect_done = 0;
    bit finished = 0;
    bit aborted = 0;
    logic [63:0] held_addr = '0;
    logic [63:0] exp_addr;

    for (int i = 0; i < FC; i++) exp_q.push_back(base + 64'(i) * LB);
    start_in = 1'b1;
    base_address_in = base;
    req_ready_in = 1'b0;
    resp_valid_in = 1'b0;
    tick();
    start_in = 1'b0;
    base_address_in = ~base;
    check("valid_after_start", 64'(req_valid_out), 64'(1));

    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (reset_at > 0 && hs_cnt == reset_at) begin
        areset = 1'b1;
        req_ready_in = 1'b0;
        resp_valid_in = 1'b0;
        #1;
        check("abort_valid", 64'(req_valid_out), 64'(0));
        check("abort_busy", 64'(busy_out), 64'(0));
        check("abort_done", 64'(done_out), 64'(0));
        check("abort_issued", 64'(issued_count_out), 64'(0));
        check("abort_addr", req_address_out, 64'(0));
        for (int k = 0; k < 3; k++) begin
          tick();
          check("abort_no_done", 64'(done_out), 64'(0));
        end
        areset = 1'b0;
        exp_q.delete();
        tick();
        check("abort_idle_busy", 64'(busy_out), 64'(0));
        aborted = 1;
        break;
      end
      check("issued", 64'(issued_count_out), 64'(hs_cnt));
      check("busy", 64'(busy_out), 64'(1));
      if (held) begin
        check("hold_valid", 64'(req_valid_out), 64'(1));
        check("hold_addr", req_address_out, held_addr);
      end
      check("done", 64'(done_out), 64'(expect_done));
      if (done_out) begin
        finished = 1;
        break;
      end
      ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      hs = req_valid_out && ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("extra_request", 64'(1), 64'(0));
        end else begin
          exp_addr = exp_q.pop_front();
          check("addr", req_address_out, exp_addr);
        end
        hs_cnt++;
      end
      held = req_valid_out && !ready;
      held_addr = req_address_out;
      if (hs_cnt == FC) drain_wait++;
      if (resp_mode == 0) resp = hs_prev;
      else resp = (drain_wait > 4) && (resp_cnt < FC);
      hs_prev = hs;
      if (resp) resp_cnt++;
      expect_done = resp && (resp_cnt == FC);
      req_ready_in = ready;
      resp_valid_in = resp;
      start_in = start_mid && (cyc == 10);
      base_address_in = start_in ? 64'hDEAD_BEEF_0000_0000 : ~base;
      tick();
    end

    req_ready_in = 1'b0;
    resp_valid_in = 1'b0;
    start_in = 1'b0;
    if (!aborted) begin
      check("flush_complete", 64'(finished), 64'(1));
      if (start_at_done) begin
        start_in = 1'b1;
        base_address_in = 64'h7777_0000;
      end
      tick();
      start_in = 1'b0;
      check("post_done_pulse", 64'(done_out), 64'(0));
      check("post_busy", 64'(busy_out), 64'(0));
      check("post_valid", 64'(req_valid_out), 64'(0));
      check("post_issued", 64'(issued_count_out), 64'(FC));
      tick();
      check("idle_busy", 64'(busy_out), 64'(0));
      check("idle_valid", 64'(req_valid_out), 64'(0));
      check("idle_issued_hold", 64'(issued_count_out), 64'(FC));
      check("queue_empty", 64'(exp_q.size()), 64'(0));
    end
  endtask

  initial begin
    areset = 1'b1;
    start_in = 1'b0;
    base_address_in = '0;
    req_ready_in = 1'b0;
    resp_valid_in = 1'b0;
    s_start = 1'b0;
    s_base = '0;
    s_ready = 1'b0;
    s_resp = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(req_valid_out), 64'(0));
    check("rst_addr", req_address_out, 64'(0));
    check("rst_busy", 64'(busy_out), 64'(0));
    check("rst_done", 64'(done_out), 64'(0));
    check("rst_issued", 64'(issued_count_out), 64'(0));
    areset = 1'b0;
    tick();

    run_flush(64'h1000_0000, 0, 0, 0, 1'b0, 1'b1);
    run_flush(64'h2000_0000, 1, 0, 0, 1'b0, 1'b0);
    run_flush(64'h3000_0000, 0, 1, 0, 1'b0, 1'b0);

    // Stray response while idle must not disturb the next flush.
    resp_valid_in = 1'b1;
    tick();
    resp_valid_in = 1'b0;
    check("stray_resp_busy", 64'(busy_out), 64'(0));
    run_flush(64'hFFFF_FFFF_FFFF_FFC0, 0, 0, 0, 1'b0, 1'b0);

    run_flush(64'h4000_0000, 0, 0, 100, 1'b1, 1'b0);
    run_flush(64'h5000_0000, 0, 0, 0, 1'b0, 1'b0);

    // Single-line geometry
    s_base = 64'h0040_0000;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_base = '0;
    check("s_valid", 64'(s_valid), 64'(1));
    check("s_addr", s_addr, 64'h0040_0000);
    check("s_busy", 64'(s_busy), 64'(1));
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check("s_drain_valid", 64'(s_valid), 64'(0));
    check("s_issued", 64'(s_issued), 64'(1));
    check("s_drain_done", 64'(s_done), 64'(0));
    s_resp = 1'b1;
    tick();
    s_resp = 1'b0;
    check("s_done", 64'(s_done), 64'(1));
    tick();
    check("s_done_low", 64'(s_done), 64'(0));
    check("s_idle_busy", 64'(s_busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
